seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multi-digit hex 7-segment driver: double-buffered digit data with
// frame-synchronous commit, static per-digit outputs and a multiplexed scan
// output. Segments are active-low, bit0..bit6 = a..g, bit7 = decimal point.
module seg7_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     en_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [8*DIGITS-1:0]   seg_all,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Hex nibble to active-low pattern; bit7 carries the inverted decimal point.
  function automatic logic [7:0] decode(input logic [3:0] nib, input logic dpb);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return {~dpb, s};
  endfunction

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         fcnt;
  logic                  phase;

  logic [4*DIGITS-1:0]   pnd_data, act_data;
  logic [DIGITS-1:0]     pnd_dp, act_dp;
  logic [DIGITS-1:0]     pnd_en, act_en;
  logic [DIGITS-1:0]     pnd_blink, act_blink;
  logic                  pnd_lz, act_lz;

  logic [8*DIGITS-1:0]   eff;
  logic                  zero_run;
  logic                  presc_last;
  logic                  idx_last;

  assign presc_last = (presc == PW'(SCAN_DIV - 1));
  assign idx_last   = (idx == IW'(DIGITS - 1));

  // Scan timing: slot prescaler, digit index and the frame-wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= presc_last && idx_last;
      if (presc_last) begin
        presc <= '0;
        idx   <= idx_last ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Blink phase flips every BLINK_FRAMES frames; starts in the on phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b1;
    end else if (frame_tick) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Double buffer: loads land in pending, commit only at a frame boundary.
  // A load coinciding with the boundary bypasses straight into active.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      pnd_data  <= '0;
      pnd_dp    <= '0;
      pnd_en    <= '0;
      pnd_blink <= '0;
      pnd_lz    <= 1'b0;
      act_data  <= '0;
      act_dp    <= '0;
      act_en    <= '0;
      act_blink <= '0;
      act_lz    <= 1'b0;
    end else if (load && frame_tick) begin
      pending   <= 1'b0;
      act_data  <= data;
      act_dp    <= dp;
      act_en    <= en_mask;
      act_blink <= blink_mask;
      act_lz    <= lz_blank;
    end else if (load) begin
      pending   <= 1'b1;
      pnd_data  <= data;
      pnd_dp    <= dp;
      pnd_en    <= en_mask;
      pnd_blink <= blink_mask;
      pnd_lz    <= lz_blank;
    end else if (frame_tick && pending) begin
      pending   <= 1'b0;
      act_data  <= pnd_data;
      act_dp    <= pnd_dp;
      act_en    <= pnd_en;
      act_blink <= pnd_blink;
      act_lz    <= pnd_lz;
    end
  end

  // Effective pattern per digit: disable, blink-off, leading-zero, decode.
  always_comb begin
    eff      = '1;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_data[4*i +: 4] == 4'h0);
      if (!act_en[i])
        eff[8*i +: 8] = 8'hFF;
      else if (!phase && act_blink[i])
        eff[8*i +: 8] = 8'hFF;
      else if (act_lz && zero_run && (i != 0))
        eff[8*i +: 8] = 8'hFF;
      else
        eff[8*i +: 8] = decode(act_data[4*i +: 4], act_dp[i]);
    end
  end

  // Registered outputs: static buses plus the scan pair, updated together.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_all <= '1;
      seg_out <= 8'hFF;
      dig_sel <= '1;
    end else begin
      seg_all      <= eff;
      seg_out      <= eff[8*idx +: 8];
      dig_sel      <= '1;
      dig_sel[idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  en_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_blank = 1'b0;
  logic        pending;
  logic        frame_tick;
  logic [31:0] seg_all;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp(dp),
    .en_mask(en_mask), .blink_mask(blink_mask), .lz_blank(lz_blank),
    .pending(pending), .frame_tick(frame_tick), .seg_all(seg_all),
    .seg_out(seg_out), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    step();
    while (!frame_tick && n < 64) begin
      step();
      n++;
    end
    chk("frame_tick_timeout", {31'b0, frame_tick}, 32'h1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                         input logic [3:0] b, input logic lz);
    load = 1'b1; data = d; dp = p; en_mask = e; blink_mask = b; lz_blank = lz;
  endtask

  logic [7:0] exp_b [4];

  initial begin
    exp_b[0] = 8'h8E; exp_b[1] = 8'h88; exp_b[2] = 8'hA4; exp_b[3] = 8'hF9;

    // reset state
    step(); step(); step();
    chk("rst_seg_all", seg_all, 32'hFFFFFFFF);
    chk("rst_seg_out", {24'b0, seg_out}, 32'hFF);
    chk("rst_dig_sel", {28'b0, dig_sel}, 32'hF);
    chk("rst_pending", {31'b0, pending}, 32'h0);
    chk("rst_frame_tick", {31'b0, frame_tick}, 32'h0);

    // basic load and frame-synchronous commit
    rst = 1'b0;
    do_load(16'h12AF, 4'h0, 4'hF, 4'h0, 1'b0);
    step(); load = 1'b0;
    chk("dig_sel_first", {28'b0, dig_sel}, 32'hE);
    chk("pend_set", {31'b0, pending}, 32'h1);
    chk("seg_all_before_commit", seg_all, 32'hFFFFFFFF);
    wait_tick();
    chk("pend_at_tick", {31'b0, pending}, 32'h1);
    step();
    chk("pend_cleared", {31'b0, pending}, 32'h0);
    step();
    chk("seg_all_12AF", seg_all, 32'hF9A4888E);

    // scan sequence over one full frame
    wait_tick();
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("dig_sel_%0d", k), {28'b0, dig_sel}, {28'b0, ~(4'b0001 << ((k - 1) / 4))});
      chk($sformatf("seg_out_%0d", k), {24'b0, seg_out}, {24'b0, exp_b[(k - 1) / 4]});
      if (k == 8)  chk("ftick_mid", {31'b0, frame_tick}, 32'h0);
      if (k == 16) chk("ftick_16", {31'b0, frame_tick}, 32'h1);
    end

    // load on the frame_tick cycle: bypass, with leading-zero blanking
    do_load(16'h0050, 4'b0100, 4'hF, 4'h0, 1'b1);
    step(); load = 1'b0;
    chk("bypass_pend", {31'b0, pending}, 32'h0);
    step();
    chk("seg_all_lz", seg_all, 32'hFFFF92C0);

    // two loads inside one frame: only the second commits, at the boundary
    do_load(16'h1111, 4'h0, 4'hF, 4'h0, 1'b0);
    step();
    do_load(16'h0000, 4'h0, 4'hF, 4'h0, 1'b1);
    step(); load = 1'b0;
    chk("dbl_pend", {31'b0, pending}, 32'h1);
    chk("dbl_hold", seg_all, 32'hFFFF92C0);
    wait_tick(); step(); step();
    chk("seg_all_zero_lz", seg_all, 32'hFFFFFFC0);

    // reset mid-frame with a load pending
    do_load(16'hABCD, 4'hF, 4'hF, 4'h0, 1'b0);
    step(); load = 1'b0;
    chk("pre_rst_pend", {31'b0, pending}, 32'h1);
    rst = 1'b1;
    step();
    chk("mrst_seg_out", {24'b0, seg_out}, 32'hFF);
    chk("mrst_dig_sel", {28'b0, dig_sel}, 32'hF);
    chk("mrst_seg_all", seg_all, 32'hFFFFFFFF);
    chk("mrst_pend", {31'b0, pending}, 32'h0);
    rst = 1'b0;
    wait_tick(); step(); step();
    chk("post_rst_dark", seg_all, 32'hFFFFFFFF);
    chk("post_rst_pend", {31'b0, pending}, 32'h0);
    wait_tick(); step(); step();
    chk("post_rst_dark2", seg_all, 32'hFFFFFFFF);

    // blink on digit 0 from a known phase
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_load(16'h12AF, 4'h0, 4'hF, 4'b0001, 1'b0);
    step(); load = 1'b0;
    wait_tick(); step(); step();
    chk("blink_on1", seg_all, 32'hF9A4888E);
    wait_tick(); step(); step();
    chk("blink_off1", seg_all, 32'hF9A488FF);
    wait_tick(); step(); step();
    chk("blink_off2", seg_all, 32'hF9A488FF);
    wait_tick(); step(); step();
    chk("blink_on2", seg_all, 32'hF9A4888E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
